// File: rtl/alu_seq.sv
// alu_seq: RV32 R-type sequencer with single-cycle base ops and a
// 32-step iterative mul/div engine behind valid/ready handshakes.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int CW = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [XLEN-1:0] opa, opb, acc, res_q;
    logic [CW-1:0]   cnt;
    logic            ill_q, neg_q, neg_r, rem_op;

    logic accept, last;
    logic k_mul, k_div, k_base, k_ill;
    logic sgn, rem, div0, ovf, special;
    logic [XLEN-1:0] alu, spec_res, mag_a, mag_b;
    logic [4:0]      shamt;

    assign accept = in_valid && in_ready;
    assign last   = cnt == CW'(ITER - 1);

    always_comb begin
        k_mul  = 1'b0;
        k_div  = 1'b0;
        k_base = 1'b0;
        k_ill  = 1'b0;
        unique case (1'b1)
            func7 == 7'b0000001 && func3 == 3'b000: k_mul = 1'b1;
            func7 == 7'b0000001 && func3[2]:        k_div = 1'b1;
            func7 == 7'b0000000,
            func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101):
                k_base = 1'b1;
            default: k_ill = 1'b1;
        endcase
    end

    assign shamt = rs2[4:0];

    always_comb begin
        alu = '0;
        case (func3)
            3'b000: alu = func7[5] ? rs1 - rs2 : rs1 + rs2;
            3'b001: alu = rs1 << shamt;
            3'b010: alu = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            3'b011: alu = {{(XLEN-1){1'b0}}, rs1 < rs2};
            3'b100: alu = rs1 ^ rs2;
            3'b101: alu = func7[5] ? XLEN'($signed(rs1) >>> shamt)
                                   : rs1 >> shamt;
            3'b110: alu = rs1 | rs2;
            default: alu = rs1 & rs2;
        endcase
    end

    // DIV/REM are signed (func3[0]=0); REM/REMU have func3[1]=1
    assign sgn     = ~func3[0];
    assign rem     = func3[1];
    assign div0    = rs2 == '0;
    assign ovf     = sgn && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1;
    assign special = div0 || ovf;
    assign spec_res = div0 ? (rem ? rs1 : '1) : (rem ? '0 : rs1);
    assign mag_a   = (sgn && rs1[XLEN-1]) ? -rs1 : rs1;
    assign mag_b   = (sgn && rs2[XLEN-1]) ? -rs2 : rs2;

    logic [XLEN-1:0] mul_nx, rem_nx, quo_nx, q_fix, r_fix;
    logic [XLEN:0]   rs_sh, sub;
    logic            ge;

    assign mul_nx = acc + (opb[0] ? opa : '0);
    assign rs_sh  = {acc, opa[XLEN-1]};
    assign sub    = rs_sh - {1'b0, opb};
    assign ge     = rs_sh >= {1'b0, opb};
    assign rem_nx = ge ? sub[XLEN-1:0] : rs_sh[XLEN-1:0];
    assign quo_nx = {opa[XLEN-2:0], ge};
    assign q_fix  = neg_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_r ? -rem_nx : rem_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                if (k_mul)                  state_nx = MUL;
                else if (k_div && !special) state_nx = DIV;
                else                        state_nx = DONE;
            end
            MUL:  if (last) state_nx = DONE;
            DIV:  if (last) state_nx = DONE;
            default: if (out_ready) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            res_q  <= '0;
            cnt    <= '0;
            ill_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rem_op <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt   <= '0;
                    ill_q <= 1'b0;
                    unique case (1'b1)
                        k_base: res_q <= alu;
                        k_ill: begin
                            res_q <= '0;
                            ill_q <= 1'b1;
                        end
                        k_mul: begin
                            opa <= rs1;
                            opb <= rs2;
                            acc <= '0;
                        end
                        default: begin
                            if (special) begin
                                res_q <= spec_res;
                            end else begin
                                opa    <= mag_a;
                                opb    <= mag_b;
                                acc    <= '0;
                                neg_q  <= sgn && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                                neg_r  <= sgn && rs1[XLEN-1];
                                rem_op <= rem;
                            end
                        end
                    endcase
                end
                MUL: begin
                    acc <= mul_nx;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + 1'b1;
                    if (last) res_q <= mul_nx;
                end
                DIV: begin
                    opa <= quo_nx;
                    acc <= rem_nx;
                    cnt <= cnt + 1'b1;
                    if (last) res_q <= rem_op ? r_fix : q_fix;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state == MUL || state == DIV;
    assign result    = res_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with a scoreboard queue and an
// independent output monitor for alu_seq.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] rs1, rs2;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        illegal, busy;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic        ill;
        int          lat;
        int          bz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: latency, busy span, result and illegal per response
    bit seen = 0;
    int rise = 0;
    int bcnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
            bcnt = 0;
        end else begin
            if (busy) bcnt++;
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    rise = cyc;
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected out_valid: got %h", result);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check({e.nm, ".result"}, result, e.res);
                        check({e.nm, ".illegal"}, 32'(illegal), 32'(e.ill));
                        check({e.nm, ".latency"}, rise - e.acc + 1, e.lat);
                        check({e.nm, ".busy"}, bcnt, e.bz);
                    end
                    seen = 0;
                    bcnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input logic il, input int lat, input int bz,
                         input bit push = 1);
        exp_t e;
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        check({nm, ".ready"}, 32'(in_ready), 32'd1);
        func7 = f7;
        func3 = f3;
        rs1 = a;
        rs2 = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        e.nm = nm;
        e.res = r;
        e.ill = il;
        e.lat = lat;
        e.bz = bz;
        e.acc = cyc;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 200 && (sb.size() != 0 || !in_ready); i++) tick();
        if (i == 200) begin
            nvec++;
            nfail++;
            $display("FAIL %s timeout: got busy expected done", nm);
            sb.delete();
        end
    endtask

    task automatic op(input string nm, input logic [6:0] f7,
                      input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r,
                      input logic il, input int lat, input int bz);
        issue(nm, f7, f3, a, b, r, il, lat, bz);
        wait_done(nm);
    endtask

    localparam logic [6:0] B = 7'b0000000;
    localparam logic [6:0] A = 7'b0100000;
    localparam logic [6:0] M = 7'b0000001;

    initial begin
        int ov;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        func3 = '0;
        func7 = '0;
        rs1 = '0;
        rs2 = '0;
        #12;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // backpressure on the first ADD
        out_ready = 1'b0;
        issue("add", B, 3'b000, 32'd5, 32'hFFFF_FFFF, 32'd4, 1'b0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            check("bp.result", result, 32'd4);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        wait_done("add");

        op("sub", A, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 0);
        op("sll", B, 3'b001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1, 0);
        op("sra", A, 3'b101, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1, 0);
        op("srl", B, 3'b101, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1, 0);
        op("slt", B, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 0);
        op("sltu", B, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 0);
        op("xor", B, 3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1, 0);
        op("or", B, 3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1, 0);
        op("and", B, 3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1, 0);

        // a request held while busy must not be taken
        issue("mul1", M, 3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 33, 32);
        func7 = B;
        func3 = 3'b000;
        rs1 = 32'd1;
        rs2 = 32'd1;
        in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        wait_done("mul1");

        op("mul2", M, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33, 32);
        op("div", M, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, 32);
        op("rem", M, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, 32);
        op("div_np", M, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33, 32);
        op("rem_np", M, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 33, 32);
        op("divu", M, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 32);
        op("remu", M, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33, 32);
        op("divu_max", M, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 33, 32);
        op("divu0", M, 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
        op("remu0", M, 3'b111, 32'd7, 32'd0, 32'd7, 1'b0, 1, 0);
        op("div0", M, 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
        op("div_ovf", M, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0);
        op("rem_ovf", M, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 0);
        op("mulh", M, 3'b001, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
        op("alt111", A, 3'b111, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);
        op("f7bad", 7'b0000010, 3'b000, 32'd3, 32'd4, 32'd0, 1'b1, 1, 0);

        // reset in the middle of a divide discards it
        issue("abort", M, 3'b101, 32'd100, 32'd7, 32'd0, 1'b0, 0, 0, 0);
        repeat (12) tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.result", result, 32'd0);
        tick();
        rst = 1'b0;
        ov = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov++;
            tick();
        end
        check("abort.no_out_valid", ov, 0);
        check("abort.ready_after", 32'(in_ready), 32'd1);
        op("add_after", B, 3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 1, 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
